acc_core: RTL and testbench



---
 rtl/core_defs.sv | 43 ++++
 rtl/core_regfile.sv | 41 ++++
 rtl/acc_core.sv | 184 ++++++++++++++++++
 tb/tb_acc_core.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_defs.sv
// Shared definitions for the acc_core accumulator processor:
// opcode and FSM encodings, instruction field positions and a counter helper.
package core_defs;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_SHL = 4'h6,
        OP_SHR = 4'h7,
        OP_MOV = 4'h8,
        OP_MVR = 4'h9,
        OP_LDI = 4'hA,
        OP_LD  = 4'hB,
        OP_ST  = 4'hC,
        OP_BRZ = 4'hD,
        OP_BRA = 4'hE,
        OP_HLT = 4'hF
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_MEM  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam int IW      = 9;
    localparam int OP_MSB  = 8;
    localparam int OP_LSB  = 5;
    localparam int RX_MSB  = 4;
    localparam int RX_LSB  = 1;
    localparam int IMM_MSB = 4;
    localparam int CTW     = 16;

    function automatic logic [CTW-1:0] sat_inc(input logic [CTW-1:0] v);
        return (v == {CTW{1'b1}}) ? v : v + CTW'(1);
    endfunction

endpackage

// File: rtl/core_regfile.sv
// Register file for acc_core: one combinational read port, r0 always visible,
// one write port. Indices at or above NREG read as zero and ignore writes.
module core_regfile #(
    parameter int DW   = 8,
    parameter int NREG = 16
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          we_i,
    input  logic [3:0]    wr_idx_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic [3:0]    rd_idx_i,
    output logic [DW-1:0] rd_data_o,
    output logic [DW-1:0] r0_o
);

    logic [DW-1:0] regs_q [NREG];

    // NOTE: the array is cleared by reset because the architecture defines
    // every register as 0 after reset; it is flops, not an inferred RAM.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_idx_i == 4'(i)) regs_q[i] <= wr_data_i;
            end
        end
    end

    // Decoding by comparison keeps out-of-range indices from aliasing.
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < NREG; i++) begin
            if (rd_idx_i == 4'(i)) rd_data_o = regs_q[i];
        end
    end

    assign r0_o = regs_q[0];

endmodule

// File: rtl/acc_core.sv
// Single-issue accumulator core with run-control FSM, handshake data memory
// and cycle counter. Optional perf counters are enabled by CORE_PERF_EN.
module acc_core
    import core_defs::*;
#(
    parameter int DW   = 8,
    parameter int NREG = 16,
    parameter int PCW  = 10
) (
    input  logic            CLK,
    input  logic            reset_n,
    input  logic            start,
    output logic [PCW-1:0]  imem_addr,
    input  logic [IW-1:0]   imem_data,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack,
    output logic            busy,
    output logic            halt,
    output logic [DW-1:0]   acc,
    output logic [CTW-1:0]  cycle_ct,
    output logic [CTW-1:0]  instr_ct,
    output logic [CTW-1:0]  stall_ct
);

    state_t          state_q, state_d;
    logic [PCW-1:0]  pc_q, pc_d, pc_inc, pc_br;
    logic [DW-1:0]   maddr_q, maddr_d, mwdata_q, mwdata_d;
    logic            mwe_q, mwe_d;
    logic [CTW-1:0]  cyc_q, cyc_d;

    op_t             op;
    logic [3:0]      rx_idx;
    logic [4:0]      imm5;
    logic [DW-1:0]   r0, rx_val, rf_wdata;
    logic [3:0]      rf_widx;
    logic            rf_we, start_ok, issue_mem;

    assign op        = op_t'(imem_data[OP_MSB:OP_LSB]);
    assign rx_idx    = imem_data[RX_MSB:RX_LSB];
    assign imm5      = imem_data[IMM_MSB:0];
    assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_HALT);
    assign issue_mem = (state_q == ST_RUN) && (op == OP_LD || op == OP_ST);
    assign pc_inc    = pc_q + PCW'(1);
    assign pc_br     = pc_q + PCW'($signed(imm5));

    core_regfile #(.DW(DW), .NREG(NREG)) u_regfile (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .we_i      (rf_we),
        .wr_idx_i  (rf_widx),
        .wr_data_i (rf_wdata),
        .rd_idx_i  (rx_idx),
        .rd_data_o (rx_val),
        .r0_o      (r0)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HALT: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (issue_mem)          state_d = ST_MEM;
                else if (op == OP_HLT)  state_d = ST_HALT;
            end
            ST_MEM:  if (mem_ack) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == ST_RUN) || (state_q == ST_MEM);
        halt    = (state_q == ST_HALT);
        mem_req = (state_q == ST_MEM);
    end

    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        pc_d     = pc_q;
        maddr_d  = maddr_q;
        mwe_d    = mwe_q;
        mwdata_d = mwdata_q;
        rf_we    = 1'b0;
        rf_widx  = 4'd0;
        rf_wdata = r0;
        if (start_ok) pc_d = '0;
        if (state_q == ST_RUN) begin
            pc_d = pc_inc;
            case (op)
                OP_ADD: begin rf_we = 1'b1; rf_wdata = r0 + rx_val;   end
                OP_SUB: begin rf_we = 1'b1; rf_wdata = r0 - rx_val;   end
                OP_AND: begin rf_we = 1'b1; rf_wdata = r0 & rx_val;   end
                OP_OR:  begin rf_we = 1'b1; rf_wdata = r0 | rx_val;   end
                OP_XOR: begin rf_we = 1'b1; rf_wdata = r0 ^ rx_val;   end
                OP_SHL: begin rf_we = 1'b1; rf_wdata = r0 << 1;       end
                OP_SHR: begin rf_we = 1'b1; rf_wdata = r0 >> 1;       end
                OP_MOV: begin rf_we = 1'b1; rf_wdata = rx_val;        end
                OP_MVR: begin rf_we = 1'b1; rf_widx = rx_idx;         end
                OP_LDI: begin rf_we = 1'b1; rf_wdata = DW'(imm5);     end
                OP_LD, OP_ST: begin
                    // PC advances only when the access completes.
                    pc_d     = pc_q;
                    maddr_d  = rx_val;
                    mwe_d    = (op == OP_ST);
                    mwdata_d = r0;
                end
                OP_BRZ: pc_d = (r0 == '0) ? pc_br : pc_inc;
                OP_BRA: pc_d = pc_br;
                OP_HLT: pc_d = pc_q;
                default: ;
            endcase
        end else if (state_q == ST_MEM && mem_ack) begin
            pc_d = pc_inc;
            if (!mwe_q) begin
                rf_we    = 1'b1;
                rf_wdata = mem_rdata;
            end
        end
        if (start_ok)  cyc_d = '0;
        else if (busy) cyc_d = sat_inc(cyc_q);
        else           cyc_d = cyc_q;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            pc_q     <= '0;
            maddr_q  <= '0;
            mwe_q    <= 1'b0;
            mwdata_q <= '0;
            cyc_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            maddr_q  <= maddr_d;
            mwe_q    <= mwe_d;
            mwdata_q <= mwdata_d;
            cyc_q    <= cyc_d;
        end
    end

    assign imem_addr = pc_q;
    assign mem_we    = mwe_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = mwdata_q;
    assign acc       = r0;
    assign cycle_ct  = cyc_q;

`ifdef CORE_PERF_EN
    logic [CTW-1:0] instr_q, stall_q;
    logic           retire;

    assign retire = ((state_q == ST_RUN) && !issue_mem) || ((state_q == ST_MEM) && mem_ack);

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            instr_q <= '0;
            stall_q <= '0;
        end else if (start_ok) begin
            instr_q <= '0;
            stall_q <= '0;
        end else begin
            if (retire)             instr_q <= sat_inc(instr_q);
            if (state_q == ST_MEM)  stall_q <= sat_inc(stall_q);
        end
    end

    assign instr_ct = instr_q;
    assign stall_ct = stall_q;
`else
    assign instr_ct = '0;
    assign stall_ct = '0;
`endif

endmodule

// File: tb/tb_acc_core.sv
// Directed bench for acc_core: programs in a ROM model, a handshake data
// memory driven from a scoreboard of expected transactions.
module tb_acc_core;
    import core_defs::*;

    localparam int DW   = 8;
    localparam int NREG = 4;
    localparam int PCW  = 4;
`ifdef CORE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic            CLK, reset_n, start;
    logic [PCW-1:0]  imem_addr;
    logic [IW-1:0]   imem_data;
    logic            mem_req, mem_we, mem_ack;
    logic [DW-1:0]   mem_addr, mem_wdata, mem_rdata, acc;
    logic            busy, halt;
    logic [15:0]     cycle_ct, instr_ct, stall_ct;

    logic [IW-1:0]   rom  [16];
    logic [DW-1:0]   dmem [256];

    typedef struct {
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_txn_t;

    mem_txn_t sb[$];
    int checks   = 0;
    int failures = 0;
    int ack_dly  = 3;

    assign imem_data = rom[imem_addr];

    acc_core #(.DW(DW), .NREG(NREG), .PCW(PCW)) dut (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .start     (start),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .halt      (halt),
        .acc       (acc),
        .cycle_ct  (cycle_ct),
        .instr_ct  (instr_ct),
        .stall_ct  (stall_ct)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] ins(input op_t op, input logic [3:0] x);
        return {op, x, 1'b0};
    endfunction

    function automatic logic [IW-1:0] imm(input op_t op, input logic [4:0] v);
        return {op, v};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = ins(OP_NOP, 4'd0);
    endtask

    task automatic pulse_start();
        @(negedge CLK) start = 1'b1;
        @(negedge CLK) start = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 200 && !halt; i++) @(negedge CLK);
        check(tag, halt, 1);
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 50 && !mem_req; i++) @(negedge CLK);
        check(tag, mem_req, 1);
    endtask

    task automatic check_perf(input string tag, input int ni, input int ns);
        check({tag, "_instr"}, instr_ct, PERF ? ni : 0);
        check({tag, "_stall"}, stall_ct, PERF ? ns : 0);
    endtask

    // Data-memory responder: pops the expected transaction when a request
    // appears, acks in the ack_dly-th request cycle and checks the drop.
    initial begin
        mem_txn_t exp_t;
        int       n;
        logic     stable, acked;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge CLK);
            if (mem_req && reset_n) begin
                check("sb_nonempty", sb.size() != 0, 1);
                exp_t = (sb.size() != 0) ? sb.pop_front() : '{we: 1'b0, addr: '0, wdata: '0};
                check("mem_we", mem_we, exp_t.we);
                check("mem_addr", mem_addr, exp_t.addr);
                if (exp_t.we) check("mem_wdata", mem_wdata, exp_t.wdata);
                n = 0; stable = 1'b1; acked = 1'b0;
                while (mem_req && reset_n && n < 2000) begin
                    n++;
                    if (mem_we !== exp_t.we || mem_addr !== exp_t.addr ||
                        (exp_t.we && mem_wdata !== exp_t.wdata)) stable = 1'b0;
                    if (n == ack_dly) begin
                        mem_ack = 1'b1;
                        acked   = 1'b1;
                        if (exp_t.we) dmem[mem_addr] = mem_wdata;
                        else          mem_rdata = dmem[mem_addr];
                    end
                    @(negedge CLK);
                    mem_ack = 1'b0;
                end
                check("mem_stable", stable, 1);
                if (acked) check("mem_req_len", n, ack_dly);
            end
        end
    end

    initial begin
        reset_n = 1'b1;
        start   = 1'b0;
        clear_rom();
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        #3 reset_n = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_busy", busy, 0);
        check("rst_halt", halt, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_acc", acc, 0);
        check("rst_pc", imem_addr, 0);
        check("rst_cyc", cycle_ct, 0);
        check_perf("rst", 0, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge CLK);
        check("idle_wait", busy, 0);

        // LDI 5; MVR r1; LDI 3; ADD r1; HLT
        rom[0] = imm(OP_LDI, 5'd5);
        rom[1] = ins(OP_MVR, 4'd1);
        rom[2] = imm(OP_LDI, 5'd3);
        rom[3] = ins(OP_ADD, 4'd1);
        rom[4] = ins(OP_HLT, 4'd0);
        pulse_start();
        check("p1_busy", busy, 1);
        wait_halt("p1_halt");
        check("p1_acc", acc, 8);
        check("p1_cyc", cycle_ct, 5);
        check("p1_notbusy", busy, 0);
        check_perf("p1", 5, 0);

        // Restart from HALT: PC back to 0, counters cleared, r1 = 5 kept
        clear_rom();
        rom[0] = ins(OP_ADD, 4'd1);
        rom[1] = ins(OP_HLT, 4'd0);
        pulse_start();
        check("p1b_pc0", imem_addr, 0);
        wait_halt("p1b_halt");
        check("p1b_acc", acc, 13);
        check("p1b_cyc", cycle_ct, 2);
        check_perf("p1b", 2, 0);

        // 0xFF + 1 wraps to 0, BRZ +2 skips, out-of-range register index
        clear_rom();
        rom[0]  = imm(OP_LDI, 5'd1);
        rom[1]  = ins(OP_MVR, 4'd1);
        rom[2]  = imm(OP_LDI, 5'd0);
        rom[3]  = ins(OP_SUB, 4'd1);
        rom[4]  = ins(OP_ADD, 4'd1);
        rom[5]  = imm(OP_BRZ, 5'd2);
        rom[6]  = imm(OP_LDI, 5'd7);
        rom[7]  = ins(OP_XOR, 4'd1);
        rom[8]  = ins(OP_MVR, 4'd5);
        rom[9]  = ins(OP_MOV, 4'd5);
        rom[10] = ins(OP_ADD, 4'd1);
        rom[11] = ins(OP_HLT, 4'd0);
        pulse_start();
        wait_halt("p2_halt");
        check("p2_acc", acc, 1);
        check("p2_cyc", cycle_ct, 11);
        check_perf("p2", 11, 0);

        // Logic ops and right shift
        clear_rom();
        rom[0] = imm(OP_LDI, 5'd12);
        rom[1] = ins(OP_MVR, 4'd3);
        rom[2] = imm(OP_LDI, 5'd10);
        rom[3] = ins(OP_AND, 4'd3);
        rom[4] = ins(OP_XOR, 4'd3);
        rom[5] = ins(OP_OR,  4'd1);
        rom[6] = ins(OP_SHR, 4'd0);
        rom[7] = ins(OP_HLT, 4'd0);
        pulse_start();
        wait_halt("p4_halt");
        check("p4_acc", acc, 2);
        check("p4_cyc", cycle_ct, 8);

        // Store then load back with a 3-cycle ack; start while busy ignored
        clear_rom();
        rom[0] = imm(OP_LDI, 5'd20);
        rom[1] = ins(OP_MVR, 4'd2);
        rom[2] = imm(OP_LDI, 5'd13);
        rom[3] = ins(OP_SHL, 4'd0);
        rom[4] = ins(OP_ST,  4'd2);
        rom[5] = imm(OP_LDI, 5'd0);
        rom[6] = ins(OP_LD,  4'd2);
        rom[7] = ins(OP_HLT, 4'd0);
        ack_dly = 3;
        sb.push_back('{we: 1'b1, addr: 8'd20, wdata: 8'd26});
        sb.push_back('{we: 1'b0, addr: 8'd20, wdata: 8'd0});
        pulse_start();
        wait_req("p3_req");
        start = 1'b1;
        @(negedge CLK) start = 1'b0;
        check("p3_busy_start_req", mem_req, 1);
        check("p3_busy_start_pc", imem_addr, 4);
        wait_halt("p3_halt");
        check("p3_acc", acc, 26);
        check("p3_cyc", cycle_ct, 14);
        check_perf("p3", 8, 6);

        // PCW=4: BRA -1 at 0 goes to 15, NOP at 15 wraps to 0
        clear_rom();
        rom[0] = imm(OP_BRA, 5'h1F);
        pulse_start();
        check("p5_pc0", imem_addr, 0);
        @(negedge CLK);
        check("p5_pc15", imem_addr, 15);
        @(negedge CLK);
        check("p5_wrap", imem_addr, 0);
        start = 1'b1;
        @(negedge CLK) start = 1'b0;
        check("p5_start_ignored", imem_addr, 15);
        check("p5_busy", busy, 1);

        // Reset clears the looping core
        reset_n = 1'b0;
        #1;
        check("p5_rst_busy", busy, 0);
        check("p5_rst_cyc", cycle_ct, 0);
        @(negedge CLK) reset_n = 1'b1;

        // Reset asserted in MEM drops mem_req at once
        clear_rom();
        rom[0] = imm(OP_LDI, 5'd9);
        rom[1] = ins(OP_LD, 4'd0);
        ack_dly = 1000;
        sb.push_back('{we: 1'b0, addr: 8'd9, wdata: 8'd0});
        pulse_start();
        wait_req("p6_req");
        check("p6_acc_pre", acc, 9);
        #2 reset_n = 1'b0;
        #1;
        check("p6_req_drop", mem_req, 0);
        check("p6_busy", busy, 0);
        check("p6_halt", halt, 0);
        check("p6_acc", acc, 0);
        check("p6_pc", imem_addr, 0);
        @(negedge CLK) reset_n = 1'b1;
        repeat (2) @(negedge CLK);
        check("p6_idle", busy, 0);
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
